muldiv_sequencer: RTL and testbench

- Iterative controller for the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the execution stage's ALU and receives the same op1/op2/ALU_op/ALU_op_ext operands.
- Sequences a radix-2 shift-add/shift-subtract datapath over XLEN cycles.
- Holds the core with a stall signal until the result is written back.

---
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Radix-2 shift-add multiply and restoring divide, one bit
// per cycle over XLEN cycles, with a stall output that holds the core.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply by zero skip the iteration phase and finish one cycle after accept.
// Handshake: an op is accepted on a rising edge where start=1, ALU_op_ext is
// 7'b0000001 and the unit is IDLE; res is qualified by res_valid, a one-cycle
// strobe in DONE. There is no backpressure on the result.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      ALU_op,
   input  logic [6:0]      ALU_op_ext,
   output logic            stall,
   output logic [XLEN-1:0] res,
   output logic            res_valid,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d;        // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]   acc_q, acc_d;    // mul: {partial, multiplier}; div: {unused, dividend/quotient}
   logic [XLEN:0]       rem_q, rem_d;    // partial remainder
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic                dz_q, dz_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                accept;
   logic                is_div_in, s1_in, s2_in, neg1, neg2;
   logic [XLEN-1:0]     mag1, mag2;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN+1:0]     div_shift, div_diff;
   logic                div_ok;
   logic [XLEN:0]       div_rem_next;
   logic [XLEN-1:0]     div_quo_next;
   logic [2*XLEN-1:0]   step_acc;
   logic [XLEN:0]       step_rem;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, final_res;

   // Operand decode: which operands are signed, and their magnitudes
   always_comb begin
      accept    = start && (ALU_op_ext == 7'b0000001) && (state_q == IDLE);
      is_div_in = ALU_op[2];
      s1_in     = is_div_in ? !ALU_op[0] : (ALU_op != 3'b011);
      s2_in     = is_div_in ? !ALU_op[0] : !ALU_op[1];
      neg1      = s1_in && op1[XLEN-1];
      neg2      = s2_in && op2[XLEN-1];
      mag1      = neg1 ? (~op1 + 1'b1) : op1;
      mag2      = neg2 ? (~op2 + 1'b1) : op2;
   end

   // One datapath iteration and the sign-corrected result it would complete
   always_comb begin
      mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
      mul_next     = {mul_sum, acc_q[XLEN-1:1]};
      div_shift    = {rem_q, acc_q[XLEN-1]};
      div_diff     = div_shift - {2'b00, a_q};
      div_ok       = !div_diff[XLEN+1];
      div_rem_next = div_ok ? div_diff[XLEN:0] : div_shift[XLEN:0];
      div_quo_next = {acc_q[XLEN-2:0], div_ok};
      step_acc     = op_q[2] ? {acc_q[2*XLEN-1:XLEN], div_quo_next} : mul_next;
      step_rem     = op_q[2] ? div_rem_next : rem_q;
      prod_fix     = neg_res_q ? (~step_acc + 1'b1) : step_acc;
      quo_fix      = dz_q ? {XLEN{1'b1}}
                   : (neg_res_q ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0]);
      rem_fix      = neg_rem_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
      case (op_q)
         3'b000:                 final_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quo_fix;
         default:                final_res = rem_fix;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early;
   logic [XLEN-1:0] early_res;
   logic            ovf_in;

   // Special cases whose architected result is known at accept time
   always_comb begin
      ovf_in = !ALU_op[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == {XLEN{1'b1}});
      early  = (op2 == '0) || (is_div_in && ovf_in);
      if (!is_div_in)
         early_res = '0;
      else if (op2 == '0)
         early_res = ALU_op[1] ? op1 : {XLEN{1'b1}};
      else
         early_res = ALU_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end
`endif

   // Next-state and datapath register updates; flush overrides any transition
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      op_d      = op_q;
      a_d       = a_q;
      acc_d     = acc_q;
      rem_d     = rem_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      res_d     = res_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = ALU_op;
               a_d       = is_div_in ? mag2 : mag1;
               acc_d     = {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
               rem_d     = '0;
               neg_res_d = neg1 ^ neg2;
               neg_rem_d = neg1;
               dz_d      = is_div_in && (op2 == '0);
               count_d   = CW'(XLEN - 1);
               state_d   = CALC;
`ifdef MULDIV_EARLY_OUT_EN
               if (early) begin
                  res_d   = early_res;
                  state_d = DONE;
               end
`endif
            end
         end
         CALC: begin
            acc_d   = step_acc;
            rem_d   = step_rem;
            count_d = count_q - 1'b1;
            if (count_q == '0) begin
               res_d   = final_res;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
         res_d   = res_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         op_q      <= '0;
         a_q       <= '0;
         acc_q     <= '0;
         rem_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         op_q      <= op_d;
         a_q       <= a_d;
         acc_q     <= acc_d;
         rem_q     <= rem_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         res_q     <= res_d;
      end
   end

   assign stall     = accept || (state_q == CALC);
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == DONE);
   assign res       = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: architected results, latency, stall
// window, one-shot res_valid, busy-ignore, flush and mid-op reset.
module tb_muldiv_sequencer;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst, start, flush;
   logic [XLEN-1:0] op1, op2;
   logic [2:0]      ALU_op;
   logic [6:0]      ALU_op_ext;
   logic            stall, res_valid, busy;
   logic [XLEN-1:0] res;

   int tests = 0;
   int fails = 0;

   muldiv_sequencer #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .flush      (flush),
      .op1        (op1),
      .op2        (op2),
      .ALU_op     (ALU_op),
      .ALU_op_ext (ALU_op_ext),
      .stall      (stall),
      .res        (res),
      .res_valid  (res_valid),
      .busy       (busy)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // cycles from the start cycle's edge to the res_valid cycle
   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (b == 32'h0) return 1;
      if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
      return 33;
   endfunction

   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
      int cyc, st_cnt, lat;
      lat = exp_lat(f3, a, b);
      @(negedge clk);
      start = 1'b1; ALU_op = f3; ALU_op_ext = 7'b0000001; op1 = a; op2 = b;
      #1;
      st_cnt = stall ? 1 : 0;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!res_valid && cyc < 100) begin
         if (stall) st_cnt++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " stall_cycles"}, 32'(st_cnt), 32'(lat));
      chk({tag, " res"}, res, exp);
      @(negedge clk);
      chk({tag, " valid_oneshot"}, {31'b0, res_valid}, 32'h0);
      chk({tag, " res_hold"}, res, exp);
   endtask

   initial begin
      int vcnt, vcyc;
      rst = 1'b1; start = 1'b0; flush = 1'b0;
      op1 = '0; op2 = '0; ALU_op = '0; ALU_op_ext = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset busy", {31'b0, busy}, 32'h0);
      chk("reset stall", {31'b0, stall}, 32'h0);
      chk("reset res", res, 32'h0);
      chk("reset res_valid", {31'b0, res_valid}, 32'h0);

      do_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
      do_op(3'b000, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, "MUL big*9");
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min");
      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
      do_op(3'b011, 32'h8000_0000, 32'd4,         32'h0000_0002, "MULHU 2^31*4");
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");
      do_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV -7/2");
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM -7/2");
      do_op(3'b101, 32'd100,       32'd7,         32'd14,        "DIVU 100/7");
      do_op(3'b111, 32'd100,       32'd7,         32'd2,         "REMU 100/7");
      do_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "DIVU 5/0");
      do_op(3'b110, 32'd5,         32'd0,         32'd5,         "REM 5/0");
      do_op(3'b100, 32'hFFFF_FFFA, 32'd0,         32'hFFFF_FFFF, "DIV -6/0");
      do_op(3'b110, 32'hFFFF_FFFA, 32'd0,         32'hFFFF_FFFA, "REM -6/0");
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM ovf");

      // second start during an op is ignored
      @(negedge clk);
      start = 1'b1; ALU_op = 3'b101; ALU_op_ext = 7'b0000001; op1 = 32'd100; op2 = 32'd7;
      vcnt = 0; vcyc = 0;
      for (int i = 1; i <= 45; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (res_valid) begin vcnt++; vcyc = i; end
         if (i == 10) begin start = 1'b1; ALU_op = 3'b000; op1 = 32'd3; op2 = 32'd3; end
      end
      chk("busy-start valid count", 32'(vcnt), 32'd1);
      chk("busy-start valid cycle", 32'(vcyc), 32'd33);
      chk("busy-start res", res, 32'd14);

      // flush mid-op
      @(negedge clk);
      start = 1'b1; ALU_op = 3'b000; ALU_op_ext = 7'b0000001; op1 = 32'd5; op2 = 32'd5;
      vcnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         flush = 1'b0;
         if (res_valid) vcnt++;
         if (i == 16) chk("flush busy", {31'b0, busy}, 32'h0);
         if (i == 15) flush = 1'b1;
      end
      chk("flush valid count", 32'(vcnt), 32'd0);
      chk("flush res unchanged", res, 32'd14);

      // reset mid-DIV, then a non-M start
      @(negedge clk);
      start = 1'b1; ALU_op = 3'b100; ALU_op_ext = 7'b0000001; op1 = 32'd100; op2 = 32'd7;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("midrst busy", {31'b0, busy}, 32'h0);
      chk("midrst stall", {31'b0, stall}, 32'h0);
      chk("midrst res", res, 32'h0);
      chk("midrst res_valid", {31'b0, res_valid}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1; ALU_op = 3'b000; ALU_op_ext = 7'b0000000; op1 = 32'd2; op2 = 32'd3;
      #1;
      chk("non-M stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      start = 1'b0;
      chk("non-M busy", {31'b0, busy}, 32'h0);
      vcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid || busy) vcnt++;
      end
      chk("non-M no activity", 32'(vcnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
